ssd_window_sequencer: RTL

//  Initiator side of the 48-bit row MAC interface. On start, walks a 6-row left window against NUM candidate

---
 rtl/ssd_pkg.sv | 36 +++
 rtl/ssd_window_sequencer_if.sv | 27 ++
 rtl/ssd_min_tracker.sv | 35 +++
 rtl/ssd_window_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants, types and helpers for the window SSD sequencer and its minimum tracker.
package ssd_pkg;

    localparam int WIN_ROWS    = 6;
    localparam int MAX_DISP    = 32;
    localparam int RD_LATENCY  = 2;
    localparam int MAC_W       = 20;
    localparam int SUM_W       = MAC_W + $clog2(WIN_ROWS);
    localparam int TIMEOUT_CYC = 64;
    localparam int ROW_W       = 48;

    localparam int NUM_W     = $clog2(MAX_DISP) + 1;
    localparam int DISP_W    = $clog2(MAX_DISP);
    localparam int ROW_IDX_W = $clog2(WIN_ROWS);
    localparam int RADDR_W   = $clog2(MAX_DISP * WIN_ROWS);

    typedef logic [DISP_W-1:0] disp_t;
    typedef logic [SUM_W-1:0]  ssd_t;
    typedef logic [NUM_W-1:0]  num_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_RD,
        ISSUE,
        WAIT_MAC,
        COMPARE,
        DONE
    } seq_state_t;

    // Requests beyond the right buffer's capacity are reduced to the full disparity range.
    function automatic num_t clamp_num(input num_t n);
        return (n > num_t'(MAX_DISP)) ? num_t'(MAX_DISP) : n;
    endfunction

endpackage

// File: rtl/ssd_window_sequencer_if.sv
// Row-MAC request/response bundle; the master side issues row pairs, the slave side returns row SSDs.
interface ssd_window_sequencer_if;
    import ssd_pkg::*;

    logic [ROW_W-1:0] mac_left_row_out;
    logic [ROW_W-1:0] mac_right_row_out;
    logic             mac_valid_out;
    logic [MAC_W-1:0] mac_acc_in;
    logic             mac_valid_in;

    modport master (
        output mac_left_row_out,
        output mac_right_row_out,
        output mac_valid_out,
        input  mac_acc_in,
        input  mac_valid_in
    );

    modport slave (
        input  mac_left_row_out,
        input  mac_right_row_out,
        input  mac_valid_out,
        output mac_acc_in,
        output mac_valid_in
    );

endinterface

// File: rtl/ssd_min_tracker.sv
// Running minimum of window sums; o_best_* already include the candidate being compared this cycle.
module ssd_min_tracker
    import ssd_pkg::*;
(
    input  logic  clk_in,
    input  logic  rst_in,
    input  logic  i_init,
    input  logic  i_cmp,
    input  ssd_t  i_sum,
    input  disp_t i_disp,
    output ssd_t  o_best_ssd,
    output disp_t o_best_disp
);

    ssd_t  r_best_ssd;
    disp_t r_best_disp;
    logic  w_better;

    // Strict less-than: an equal sum never displaces the lower disparity already held.
    assign w_better    = i_cmp && (i_sum < r_best_ssd);
    assign o_best_ssd  = w_better ? i_sum  : r_best_ssd;
    assign o_best_disp = w_better ? i_disp : r_best_disp;

    // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in || i_init) begin
            r_best_ssd  <= '1;
            r_best_disp <= '0;
        end else begin
            r_best_ssd  <= o_best_ssd;
            r_best_disp <= o_best_disp;
        end
    end

endmodule

// File: rtl/ssd_window_sequencer.sv
// Walks a WIN_ROWS-row left window against up to MAX_DISP right candidates through a one-deep MAC
// engine and reports the minimum-SSD disparity. Optional watchdog: define SSD_SEQ_TIMEOUT_EN.
module ssd_window_sequencer
    import ssd_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  num_t                 num_disp_in,
    output logic                 busy_out,
    output logic [ROW_IDX_W-1:0] left_addr_out,
    output logic [RADDR_W-1:0]   right_addr_out,
    input  logic [ROW_W-1:0]     left_data_in,
    input  logic [ROW_W-1:0]     right_data_in,
    ssd_window_sequencer_if.master mac,
    output disp_t                best_disp_out,
    output ssd_t                 best_ssd_out,
    output logic                 done_out
`ifdef SSD_SEQ_TIMEOUT_EN
    ,
    output logic                 timeout_err_out
`endif
);

    localparam int WAIT_W = $clog2(RD_LATENCY + 1);

    seq_state_t           r_state;
    seq_state_t           w_next;
    num_t                 r_num;
    logic [ROW_IDX_W-1:0] r_row;
    disp_t                r_disp;
    ssd_t                 r_sum;
    logic [WAIT_W-1:0]    r_wait;
    logic [ROW_W-1:0]     r_left_row;
    logic [ROW_W-1:0]     r_right_row;
    logic                 r_mac_valid;
    ssd_t                 r_best_ssd;
    disp_t                r_best_disp;

    logic  w_last_row;
    logic  w_last_disp;
    logic  w_rd_done;
    logic  w_timeout;
    logic  w_init;
    logic  w_issue;
    logic  w_accum;
    logic  w_cmp;
    logic  w_publish;
    ssd_t  w_best_ssd;
    disp_t w_best_disp;

    assign w_last_row  = (r_row == ROW_IDX_W'(WIN_ROWS - 1));
    assign w_last_disp = (({1'b0, r_disp} + num_t'(1)) == r_num);
    assign w_rd_done   = (r_wait == WAIT_W'(RD_LATENCY - 1));
    assign w_publish   = w_cmp && w_last_disp;

    // Addresses come straight from the row/disparity counters, which only move outside READ..ISSUE.
    assign left_addr_out  = r_row;
    assign right_addr_out = RADDR_W'(r_disp) * RADDR_W'(WIN_ROWS) + RADDR_W'(r_row);

    assign mac.mac_left_row_out  = r_left_row;
    assign mac.mac_right_row_out = r_right_row;
    assign mac.mac_valid_out     = r_mac_valid;
    assign best_ssd_out          = r_best_ssd;
    assign best_disp_out         = r_best_disp;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (start_in) w_next = (num_disp_in != '0) ? READ : DONE;
            READ:     w_next = WAIT_RD;
            WAIT_RD:  if (w_rd_done) w_next = ISSUE;
            ISSUE:    w_next = WAIT_MAC;
            WAIT_MAC: begin
                if (mac.mac_valid_in) begin
                    w_next = w_last_row ? COMPARE : READ;
                end else if (w_timeout) begin
                    w_next = DONE;
                end
            end
            COMPARE:  w_next = w_last_disp ? DONE : READ;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        busy_out = 1'b1;
        done_out = 1'b0;
        w_init   = 1'b0;
        w_issue  = 1'b0;
        w_accum  = 1'b0;
        w_cmp    = 1'b0;
        case (r_state)
            IDLE: begin
                busy_out = 1'b0;
                w_init   = start_in;
            end
            ISSUE:    w_issue = 1'b1;
            WAIT_MAC: w_accum = mac.mac_valid_in;
            COMPARE:  w_cmp   = 1'b1;
            DONE:     done_out = 1'b1;
            default:  ;
        endcase
    end

    ssd_min_tracker u_tracker (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .i_init      (w_init),
        .i_cmp       (w_cmp),
        .i_sum       (r_sum),
        .i_disp      (r_disp),
        .o_best_ssd  (w_best_ssd),
        .o_best_disp (w_best_disp)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_num       <= '0;
            r_row       <= '0;
            r_disp      <= '0;
            r_sum       <= '0;
            r_wait      <= '0;
            r_left_row  <= '0;
            r_right_row <= '0;
            r_mac_valid <= 1'b0;
            r_best_ssd  <= '1;
            r_best_disp <= '0;
        end else begin
            r_mac_valid <= w_issue;
            if (w_issue) begin
                r_left_row  <= left_data_in;
                r_right_row <= right_data_in;
            end
            if (r_state == READ) begin
                r_wait <= '0;
            end else if (r_state == WAIT_RD) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_init) begin
                r_num  <= clamp_num(num_disp_in);
                r_row  <= '0;
                r_disp <= '0;
                r_sum  <= '0;
            end
            if (w_accum) begin
                r_sum <= r_sum + SUM_W'(mac.mac_acc_in);
                if (!w_last_row) r_row <= r_row + 1'b1;
            end
            if (w_cmp) begin
                r_sum <= '0;
                r_row <= '0;
                if (!w_last_disp) r_disp <= r_disp + 1'b1;
            end
            // Results become visible together with done_out; a timed-out run never reaches here.
            if (w_publish) begin
                r_best_ssd  <= w_best_ssd;
                r_best_disp <= w_best_disp;
            end else if (w_init && (num_disp_in == '0)) begin
                r_best_ssd  <= '1;
                r_best_disp <= '0;
            end
        end
    end

`ifdef SSD_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    assign w_timeout       = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) && !mac.mac_valid_in;
    assign timeout_err_out = r_timeout;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == WAIT_MAC) ? r_to_cnt + 1'b1 : '0;
            if (w_init) begin
                r_timeout <= 1'b0;
            end else if ((r_state == WAIT_MAC) && w_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

endmodule
